// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } sw_state_e;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned MOD60_TENS_MAX = 5;
  localparam int unsigned PRESC_W        = 4;

  // Increment a two-digit BCD value modulo 60; MSB of the result is the carry out.
  function automatic logic [2*BCD_DIGIT_W:0] mod60_inc(input logic [2*BCD_DIGIT_W-1:0] v);
    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] units;
    tens  = v[2*BCD_DIGIT_W-1:BCD_DIGIT_W];
    units = v[BCD_DIGIT_W-1:0];
    if (units != BCD_DIGIT_W'(9))
      mod60_inc = {1'b0, tens, units + BCD_DIGIT_W'(1)};
    else if (tens != BCD_DIGIT_W'(MOD60_TENS_MAX))
      mod60_inc = {1'b0, tens + BCD_DIGIT_W'(1), {BCD_DIGIT_W{1'b0}}};
    else
      mod60_inc = {1'b1, {(2*BCD_DIGIT_W){1'b0}}};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lr;
  logic       running;
  logic       lap_active;
  logic       sec_tick;
  logic [7:0] disp_mm;
  logic [7:0] disp_ss;
  logic       overflow;

  modport master (
    output btn_ss, btn_lr,
    input  running, lap_active, sec_tick, disp_mm, disp_ss, overflow
  );

  modport slave (
    input  btn_ss, btn_lr,
    output running, lap_active, sec_tick, disp_mm, disp_ss, overflow
  );
endinterface

// File: rtl/bcd_mmss_counter.sv
// BCD mm:ss live-time counter, 00:00..59:59 with wrap indication.
module bcd_mmss_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       wrap
);

  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic [8:0] ss_n;
  logic [8:0] mm_n;

  // Next time value: clear wins, otherwise seconds carry into minutes.
  always_comb begin
    ss_n = mod60_inc(ss_q);
    mm_n = mod60_inc(mm_q);
    ss_d = ss_q;
    mm_d = mm_q;
    wrap = 1'b0;
    if (clr) begin
      ss_d = '0;
      mm_d = '0;
    end else if (inc) begin
      ss_d = ss_n[7:0];
      if (ss_n[8]) begin
        mm_d = mm_n[7:0];
        wrap = mm_n[8];
      end
    end
  end

  // Time registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_q <= '0;
      mm_q <= '0;
    end else begin
      ss_q <= ss_d;
      mm_q <= mm_d;
    end
  end

  assign mm = mm_q;
  assign ss = ss_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/clear sequencing, 1 Hz prescaler,
// lap latch, sticky overflow and display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 4
) (
  input  logic      clk,
  input  logic      reset,
  stopwatch_ctrl_if.slave sw
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  sw_state_e          state_q;
  logic               running_q;
  logic               lap_active_q;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         lap_mm_q, lap_ss_q;
  logic [7:0]         live_mm, live_ss;
  logic               ovf_q;
  logic               wrap;
  logic               tick;
  logic               go_lr;
  logic               capture;
  logic               clear;

  // btn_ss has priority: a simultaneous btn_lr is dropped.
  assign go_lr   = sw.btn_lr & ~sw.btn_ss;
  assign tick    = running_q && (presc_q == PRESC_MAX);
  assign capture = (state_q == S_RUN) && go_lr;
  assign clear   = (state_q == S_PAUSE) && go_lr;

  // Control FSM with registered running/lap_active flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sw.btn_ss) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (sw.btn_ss) begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end else if (sw.btn_lr) begin
            state_q      <= S_LAP;
            lap_active_q <= 1'b1;
          end
        end
        S_LAP: begin
          if (sw.btn_ss) begin
            state_q      <= S_PAUSE;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
          end else if (sw.btn_lr) begin
            state_q      <= S_RUN;
            lap_active_q <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (sw.btn_ss) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end else if (sw.btn_lr) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          running_q    <= 1'b0;
          lap_active_q <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler advances only while counting; it holds otherwise to keep the sub-second phase.
  always_comb begin
    presc_d = presc_q;
    if (clear)
      presc_d = '0;
    else if (running_q)
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  // Prescaler, lap latch (pre-tick live value) and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      lap_mm_q <= '0;
      lap_ss_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      if (clear) begin
        lap_mm_q <= '0;
        lap_ss_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (capture) begin
          lap_mm_q <= live_mm;
          lap_ss_q <= live_ss;
        end
        if (wrap)
          ovf_q <= 1'b1;
      end
    end
  end

  bcd_mmss_counter u_time (
    .clk   (clk),
    .reset (reset),
    .inc   (tick),
    .clr   (clear),
    .mm    (live_mm),
    .ss    (live_ss),
    .wrap  (wrap)
  );

  assign sw.running    = running_q;
  assign sw.lap_active = lap_active_q;
  assign sw.sec_tick   = tick;
  assign sw.overflow   = ovf_q;
  assign sw.disp_mm    = lap_active_q ? lap_mm_q : live_mm;
  assign sw.disp_ss    = lap_active_q ? lap_ss_q : live_ss;

endmodule
